// File: rtl/cla_nibble_sequencer.sv
// Sequences a WIDTH-bit add through an external 4-bit CLA one nibble per cycle,
// LSB first, chaining the carry through a register; valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for an operand pair
//   RUN   | one nibble per edge through the external adder
//   DONE  | result held until the consumer takes it
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [N-1:0][3:0] a_reg, b_reg, sum_reg;
  logic              cin_reg, carry_reg;
  logic [KW-1:0]     k;
  logic              ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)    state_nxt = RUN;
      RUN:  if (k == K_LAST) state_nxt = DONE;
      DONE: if (out_ready)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= in_a;
          b_reg     <= in_b;
          cin_reg   <= in_cin;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
          k         <= '0;
        end
        RUN: begin
          sum_reg[k] <= cla_sum;
          carry_reg  <= cla_cout;
          k          <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Overflow: operands share a sign that the result does not.
  assign ovf = (a_reg[N-1][3] == b_reg[N-1][3]) && (sum_reg[N-1][3] != a_reg[N-1][3]);

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    out_ovf   = 1'b0;
    cla_a     = 4'h0;
    cla_b     = 4'h0;
    cla_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        cla_a   = a_reg[k];
        cla_b   = b_reg[k];
        cla_cin = (k == '0) ? cin_reg : carry_reg;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = sum_reg;
        out_cout  = carry_reg;
        out_ovf   = ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Randomized self-checking bench; the external 4-bit adder and the reference
// sum model both live here.
module tb_cla_nibble_sequencer;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_cin;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       cla_a, cla_b, cla_sum;
  logic             cla_cin, cla_cout;
  logic             out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] out_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {cla_cout, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
    longint ua, ub, us, sa, sb, ss;
    logic   ovf, cout;
    ua = longint'(a); ub = longint'(b);
    us = ua + ub + longint'(cin);
    sa = (ua >= (64'sd1 << (WIDTH-1))) ? ua - (64'sd1 << WIDTH) : ua;
    sb = (ub >= (64'sd1 << (WIDTH-1))) ? ub - (64'sd1 << WIDTH) : ub;
    ss = sa + sb + longint'(cin);
    cout = (us >= (64'sd1 << WIDTH));
    ovf  = (ss > (64'sd1 << (WIDTH-1)) - 1) || (ss < -(64'sd1 << (WIDTH-1)));
    return {ovf, cout, WIDTH'(us)};
  endfunction

  // Carry into nibble i is the carry out of the low 4*i bits.
  function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input int i);
    longint m;
    if (i == 0) return cin;
    m = (64'sd1 << (4*i)) - 1;
    return ((longint'(a) & m) + (longint'(b) & m) + longint'(cin)) >> (4*i) != 0;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int hold);
    logic [WIDTH+1:0] exp;
    int lat;
    exp = ref_add(a, b, cin);
    wait_ready();
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < N + 4) begin
      if (lat < N) begin
        chk("cla_cin",   32'(cla_cin), 32'(carry_into(a, b, cin, lat)));
        chk("cla_a_nib", 32'(cla_a),   32'((a >> (4*lat)) & 'hF));
        chk("in_ready_run", 32'(in_ready), 32'd0);
      end
      @(posedge clk); @(negedge clk); lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    for (int h = 0; h < (hold > 0 ? hold : 1); h++) begin
      chk("out_sum",  32'(out_sum),  32'(exp[WIDTH-1:0]));
      chk("out_cout", 32'(out_cout), 32'(exp[WIDTH]));
      chk("out_ovf",  32'(out_ovf),  32'(exp[WIDTH+1]));
      chk("out_valid_hold", 32'(out_valid), 32'd1);
      chk("in_ready_done",  32'(in_ready),  32'd0);
      in_a = WIDTH'($urandom); in_valid = 1'($urandom);
      if (h < hold - 1) begin @(posedge clk); @(negedge clk); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("in_ready_after",  32'(in_ready),  32'd1);
    chk("out_sum_idle",    32'(out_sum),   32'd0);
  endtask

  initial begin
    logic [WIDTH+1:0] q[$];
    logic [WIDTH+1:0] e;
    int got, sent, last_t;
    logic accepted;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_cla_a",     32'(cla_a),     32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1);
    run_op(16'h8000, 16'h8000, 1'b0, 2);
    run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 5);
    for (int i = 0; i < 10; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Reset after two RUN edges.
    wait_ready();
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cla_a",     32'(cla_a),     32'd0);
    chk("mid_rst_cla_cin",   32'(cla_cin),   32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1);

    // Back-to-back with continuous valid/ready.
    got = 0; sent = 0; last_t = -1;
    wait_ready();
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("b2b_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("b2b_sum",  32'(out_sum),  32'(e[WIDTH-1:0]));
          chk("b2b_cout", 32'(out_cout), 32'(e[WIDTH]));
          chk("b2b_ovf",  32'(out_ovf),  32'(e[WIDTH+1]));
        end
        if (last_t >= 0) chk("b2b_spacing", 32'(cyc - last_t), 32'(N + 2));
        last_t = cyc;
        got++;
      end
      accepted = in_ready && in_valid;
      if (accepted) begin q.push_back(ref_add(in_a, in_b, in_cin)); sent++; end
      @(posedge clk); #1;
      if (accepted) begin
        if (sent < 6) begin
          in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
        end else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(got), 32'd6);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
